// File: rtl/mem_buffer_pkg.sv
// mem_buffer_pkg: definitions shared by mem_buffer and mem_unbuffer.
// Holds the unload FSM state encoding, counter sizing helper and default
// word/window geometry.
package mem_buffer_pkg;

  localparam int unsigned DEF_WIDTH  = 5;
  localparam int unsigned DEF_LENGTH = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Counter width for n words; never below one bit so length=1 still builds.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_unbuffer_if.sv
// mem_unbuffer_if: load-side window handshake plus word-serial output stream.
// out_last exists only when MEM_UNBUFFER_LAST_EN is defined.
interface mem_unbuffer_if
  import mem_buffer_pkg::*;
#(
  parameter int unsigned width  = DEF_WIDTH,
  parameter int unsigned length = DEF_LENGTH
);

  logic                      load_valid;
  logic                      load_ready;
  logic [width*length-1:0]   data_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [width-1:0]          data_out;
`ifdef MEM_UNBUFFER_LAST_EN
  logic                      out_last;
`endif

  // Producer of windows and consumer of words.
  modport master (
    output load_valid, data_in, out_ready,
    input  load_ready, out_valid, data_out
`ifdef MEM_UNBUFFER_LAST_EN
    , input out_last
`endif
  );

  // The unloader itself.
  modport slave (
    input  load_valid, data_in, out_ready,
    output load_ready, out_valid, data_out
`ifdef MEM_UNBUFFER_LAST_EN
    , output out_last
`endif
  );

endinterface

// File: rtl/mem_unbuffer.sv
// mem_unbuffer: accepts a flattened width*length window in one handshake and
// emits its words MSB-first, one per accepted beat.
// Optional feature: MEM_UNBUFFER_LAST_EN adds out_last on the final word.
module mem_unbuffer
  import mem_buffer_pkg::*;
#(
  parameter int unsigned width  = DEF_WIDTH,
  parameter int unsigned length = DEF_LENGTH
) (
  input  logic           clk,
  input  logic           rst,
  mem_unbuffer_if.slave  bus
);

  localparam int unsigned CW = clog2_min1(length);
  localparam logic [CW-1:0] LAST = CW'(length - 1);

  state_t                  r_state;
  logic                    r_load_ready;
  logic                    r_out_valid;
  logic [CW-1:0]           r_cnt;
  logic [width*length-1:0] r_sr;

  // Load/send FSM with counter, shift register and registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_load_ready <= 1'b1;
      r_out_valid  <= 1'b0;
      r_cnt        <= '0;
      r_sr         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.load_valid) begin
            r_sr         <= bus.data_in;
            r_cnt        <= '0;
            r_state      <= SEND;
            r_load_ready <= 1'b0;
            r_out_valid  <= 1'b1;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            r_sr <= r_sr << width;
            if (r_cnt == LAST) begin
              r_cnt        <= '0;
              r_state      <= IDLE;
              r_load_ready <= 1'b1;
              r_out_valid  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_load_ready <= 1'b1;
          r_out_valid  <= 1'b0;
          r_cnt        <= '0;
        end
      endcase
    end
  end

  assign bus.load_ready = r_load_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.data_out   = r_sr[width*length-1 -: width];

`ifdef MEM_UNBUFFER_LAST_EN
  assign bus.out_last = r_out_valid && (r_cnt == LAST);
`endif

endmodule

// File: tb/tb_mem_unbuffer.sv
// tb_mem_unbuffer: scoreboard bench for mem_unbuffer (5x5 instance) plus a
// directed check of a length=1, width=8 instance. out_last is checked only
// when MEM_UNBUFFER_LAST_EN is defined.
module tb_mem_unbuffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_unbuffer_if #(.width(5), .length(5)) bus0 ();
  mem_unbuffer_if #(.width(8), .length(1)) bus1 ();

  mem_unbuffer #(.width(5), .length(5)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  mem_unbuffer #(.width(8), .length(1)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  typedef struct {
    logic [4:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic       prev_stall = 1'b0;
  logic [4:0] prev_data  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_window(input logic [24:0] w);
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      e.data = w[(4 - i) * 5 +: 5];
      e.last = (i == 4);
      exp_q.push_back(e);
    end
  endtask

  task automatic load0(input logic [24:0] w);
    bus0.data_in    = w;
    bus0.load_valid = 1'b1;
    tick();
    bus0.load_valid = 1'b0;
    push_window(w);
  endtask

  // Drive out_ready (held high or toggling 1,0,0,1) until load_ready returns.
  task automatic wait_idle(input bit toggle, output int cyc);
    logic [3:0] pat;
    pat = 4'b1001;
    cyc = 0;
    while (!bus0.load_ready && cyc < 60) begin
      bus0.out_ready = toggle ? pat[cyc % 4] : 1'b1;
      tick();
      cyc++;
    end
    if (cyc >= 60) chk("timeout", 32'(bus0.load_ready), 32'd1);
    bus0.out_ready = 1'b1;
  endtask

  // Scoreboard monitor: pops on every accepted beat, checks stability across stalls.
  always @(negedge clk) begin
    if (!rst && bus0.out_valid) begin
      if (prev_stall) chk("hold", 32'(bus0.data_out), 32'(prev_data));
      if (bus0.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word", 32'(bus0.data_out), 32'(e.data));
`ifdef MEM_UNBUFFER_LAST_EN
          chk("last", 32'(bus0.out_last), 32'(e.last));
`endif
        end
      end
      prev_stall = !bus0.out_ready;
      prev_data  = bus0.data_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    logic [24:0] w1, w2, w3;
    int cyc;
    w1 = {5'd10, 5'd12, 5'd3, 5'd7, 5'd1};
    w2 = {5'd31, 5'd0, 5'd17, 5'd22, 5'd9};
    w3 = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5};

    bus0.load_valid = 1'b0;
    bus0.data_in    = '0;
    bus0.out_ready  = 1'b1;
    bus1.load_valid = 1'b0;
    bus1.data_in    = '0;
    bus1.out_ready  = 1'b0;

    // Reset state
    #23;
    rst = 1'b0;
    tick();
    chk("rst_load_ready", 32'(bus0.load_ready), 32'd1);
    chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_data_out", 32'(bus0.data_out), 32'd0);
`ifdef MEM_UNBUFFER_LAST_EN
    chk("rst_out_last", 32'(bus0.out_last), 32'd0);
`endif

    // Full-rate unload: 1-cycle latency, length+1 cycles per window
    load0(w1);
    chk("lat_valid", 32'(bus0.out_valid), 32'd1);
    chk("lat_word0", 32'(bus0.data_out), 32'd10);
    wait_idle(1'b0, cyc);
    chk("cycles", 32'(cyc), 32'd5);
    chk("drain1", 32'(exp_q.size()), 32'd0);
    chk("idle_data0", 32'(bus0.data_out), 32'd0);
    chk("idle_valid", 32'(bus0.out_valid), 32'd0);

    // Back-pressure with out_ready 1,0,0,1,...
    load0(w1);
    wait_idle(1'b1, cyc);
    chk("drain2", 32'(exp_q.size()), 32'd0);

    // Load request during SEND is ignored until IDLE
    load0(w1);
    bus0.data_in    = w2;
    bus0.load_valid = 1'b1;
    wait_idle(1'b0, cyc);
    chk("w1_intact", 32'(exp_q.size()), 32'd0);
    chk("ready_for_w2", 32'(bus0.load_ready), 32'd1);
    tick();
    bus0.load_valid = 1'b0;
    push_window(w2);
    chk("w2_word0", 32'(bus0.data_out), 32'd31);
    wait_idle(1'b1, cyc);
    chk("drain3", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-SEND discards remaining words
    load0(w1);
    tick();
    tick();
    chk("pre_rst_word2", 32'(bus0.data_out), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(bus0.out_valid), 32'd0);
    chk("async_ready", 32'(bus0.load_ready), 32'd1);
    chk("async_data", 32'(bus0.data_out), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    load0(w3);
    wait_idle(1'b0, cyc);
    chk("cycles_after_rst", 32'(cyc), 32'd5);
    chk("drain4", 32'(exp_q.size()), 32'd0);

    // length=1, width=8: single beat then IDLE, holding through a stall
    chk("l1_idle_ready", 32'(bus1.load_ready), 32'd1);
    bus1.data_in    = 8'hA5;
    bus1.load_valid = 1'b1;
    bus1.out_ready  = 1'b0;
    tick();
    bus1.load_valid = 1'b0;
    chk("l1_valid", 32'(bus1.out_valid), 32'd1);
    chk("l1_data", 32'(bus1.data_out), 32'hA5);
`ifdef MEM_UNBUFFER_LAST_EN
    chk("l1_last", 32'(bus1.out_last), 32'd1);
`endif
    tick();
    chk("l1_stall_data", 32'(bus1.data_out), 32'hA5);
    chk("l1_stall_valid", 32'(bus1.out_valid), 32'd1);
    bus1.out_ready = 1'b1;
    tick();
    chk("l1_done_valid", 32'(bus1.out_valid), 32'd0);
    chk("l1_done_ready", 32'(bus1.load_ready), 32'd1);
    chk("l1_done_data", 32'(bus1.data_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_unbuffer.md
# mem_unbuffer

Parallel-to-serial unloader, the read-side counterpart of `mem_buffer`. `mem_buffer` shifts `width`-bit words in serially and presents a flattened `width*length` window. `mem_unbuffer` accepts such a flattened window in one handshake and emits its words one per accepted beat over a valid/ready stream. It sits between window-producing layers (buffer, XNOR/popcount result registers) and word-serial consumers (output FIFO, next layer's `mem_buffer`).

## Interface
- `width`, 5, bits per word
- `length`, 5, words per window (≥1)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `load_valid`  in  1  window on `data_in` is valid
- `load_ready`  out  1  block can accept a window
- `data_in`  in  width*length  flattened window; word 0 = `data_in[width*length-1 -: width]` (MSB end, oldest word in `mem_buffer` order)
- `out_valid`  out  1  `data_out` holds a valid word
- `out_ready`  in  1  consumer accepts the word
- `data_out`  out  width  current word
- `out_last`  out  1  current word is word `length-1` (only with `MEM_UNBUFFER_LAST_EN`)

## Operation
- Registers: shift register `sr` (width*length), word counter `cnt` (max(1,$clog2(length)) bits), state.
- FSM states:
  - IDLE: `load_ready`=1, `out_valid`=0. On `load_valid && load_ready`: `sr`←`data_in`, `cnt`←0, go to SEND.
  - SEND: `load_ready`=0, `out_valid`=1. On `out_valid && out_ready`: `sr`←`sr << width` (zero fill), `cnt`←`cnt+1`. If `cnt==length-1`, go to IDLE and clear `cnt`.
- `data_out` = `sr[width*length-1 -: width]` at all times, so it reads 0 in IDLE after a full unload and after reset.
- `load_valid` is ignored while in SEND. No overlap of windows. `data_in` is sampled only on the load handshake.
- Words are emitted in order word 0 … word `length-1`. Words are never dropped or duplicated under back-pressure.
- `length`=1: one beat, then IDLE.

## Timing
- Reset values: `load_ready`=1, `out_valid`=0, `data_out`=0, `out_last`=0. State=IDLE, `cnt`=0, `sr`=0.
- Load accepted at edge N: `out_valid`=1 and `data_out`=word 0 from edge N onward (1-cycle latency).
- With `out_ready` held high: one word per cycle. Last word is accepted at edge N+length. `load_ready`=1 in the following cycle, giving `length+1` cycles per window.
- `out_valid && !out_ready`: `data_out`, `out_last`, `cnt` and `sr` hold stable.
- `rst` asserted mid-SEND: immediately (asynchronously) returns to IDLE, and remaining words are discarded.
- Outputs `load_ready`, `out_valid` and `out_last` are decoded from registers only. No combinational path from `out_ready` or `load_valid` to any output.

## Configuration
- `MEM_UNBUFFER_LAST_EN` defined: `out_last` port exists. It equals `out_valid && cnt==length-1`.
- Not defined: no `out_last` port and no compare logic. All other behaviour is identical.

## Structure
- Shared package `mem_buffer_pkg` holds:
  - the state enum (IDLE, SEND);
  - a `clog2_min1` function for counter sizing;
  - default `width`/`length` constants, shared with `mem_buffer`.
- No sub-module. FSM, counter and shift register are inline; the block is too small to split.

## Test plan
- Reset then idle: after `rst` pulse → `load_ready`=1, `out_valid`=0, `data_out`=0.
- Load {5'd10,5'd12,5'd3,5'd7,5'd1} with `out_ready`=1 → `data_out` = 10, 12, 3, 7, 1 on 5 consecutive cycles. `out_last` is high only on 1. `load_ready`=1 on the sixth cycle.
- Same window with `out_ready` toggling 1,0,0,1,… → the sequence is unchanged. `data_out` holds through every stall, with no loss or repeat.
- Second `load_valid` asserted while in SEND with a different window → ignored. The first window completes intact, then the second is accepted once in IDLE.
- `rst` asserted after word 2 → `out_valid`=0 immediately. A subsequent load of {5'd1,5'd2,5'd3,5'd4,5'd5} emits 1..5 from word 0.
- `length`=1, `width`=8, load 8'hA5 → a single beat of A5 with `out_last`=1, then back to IDLE.
